// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Tracks shadow copies of the instructions in EX, MEM and WB and decides,
// for the instruction sitting in ID, whether to stall, flush or forward.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   id_valid              : ID holds a real instruction
//   id_src_a/b, *_en      : ID source registers and read enables
//   id_dst, id_dst_en     : ID destination register and write enable
//   id_is_load            : ID instruction is a load
//   ex_branch_taken       : branch resolved taken in EX this cycle
//   hazard                : hold PC and IF/ID (combinational)
//   ex_bubble             : force NOP into ID/EX (combinational)
//   flush                 : squash IF/ID (combinational)
//   fwd_a_sel, fwd_b_sel  : EX operand source 00 regfile, 01 MEM, 10 WB
//   stall_cnt             : saturating count of stalled cycles
module hazard_ctrl #(
  parameter bit          FWD_EN = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_src_a,
  input  logic [4:0]       id_src_b,
  input  logic             id_src_a_en,
  input  logic             id_src_b_en,
  input  logic [4:0]       id_dst,
  input  logic             id_dst_en,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             hazard,
  output logic             ex_bubble,
  output logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             dst_en;
    logic             is_load;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic             src_a_en;
    logic             src_b_en;
  } entry_t;

  entry_t ex_q, mem_q, wb_q;
  entry_t id_c;

  // An enabled, non-zero source that a valid writing entry produces
  function automatic logic hit(input logic             valid,
                               input logic [REG_W-1:0] dst,
                               input logic             dst_en,
                               input logic [REG_W-1:0] src,
                               input logic             src_en);
    return valid & dst_en & src_en & (src != '0) & (dst == src);
  endfunction

  function automatic logic [1:0] pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return SEL_MEM;
    else if (wb_hit) return SEL_WB;
    else             return SEL_RF;
  endfunction

  logic a_ex, b_ex, a_mem, b_mem;
  logic raw_nofwd, raw_fwd, raw_stall;
  logic a_fwd_mem, a_fwd_wb, b_fwd_mem, b_fwd_wb;

  // ID source matches against the older in-flight instructions
  assign a_ex  = hit(ex_q.valid,  ex_q.dst,  ex_q.dst_en,  id_src_a, id_src_a_en);
  assign b_ex  = hit(ex_q.valid,  ex_q.dst,  ex_q.dst_en,  id_src_b, id_src_b_en);
  assign a_mem = hit(mem_q.valid, mem_q.dst, mem_q.dst_en, id_src_a, id_src_a_en);
  assign b_mem = hit(mem_q.valid, mem_q.dst, mem_q.dst_en, id_src_b, id_src_b_en);

  // Without forwarding WB is covered by regfile write-through
  assign raw_nofwd = id_valid & (a_ex | b_ex | a_mem | b_mem);
  // With forwarding only a load result still in EX is unavailable
  assign raw_fwd   = id_valid & ex_q.is_load & (a_ex | b_ex);
  assign raw_stall = FWD_EN ? raw_fwd : raw_nofwd;

  // EX operands looked up against MEM and WB; a bubble in EX reads nothing
  assign a_fwd_mem = ex_q.valid & hit(mem_q.valid, mem_q.dst, mem_q.dst_en, ex_q.src_a, ex_q.src_a_en);
  assign a_fwd_wb  = ex_q.valid & hit(wb_q.valid,  wb_q.dst,  wb_q.dst_en,  ex_q.src_a, ex_q.src_a_en);
  assign b_fwd_mem = ex_q.valid & hit(mem_q.valid, mem_q.dst, mem_q.dst_en, ex_q.src_b, ex_q.src_b_en);
  assign b_fwd_wb  = ex_q.valid & hit(wb_q.valid,  wb_q.dst,  wb_q.dst_en,  ex_q.src_b, ex_q.src_b_en);

  // Control outputs; a taken branch discards the ID instruction so it never stalls
  always_comb begin
    hazard    = 1'b0;
    flush     = 1'b0;
    ex_bubble = 1'b0;
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (!reset) begin
      hazard    = raw_stall & ~ex_branch_taken;
      flush     = ex_branch_taken;
      ex_bubble = (raw_stall & ~ex_branch_taken) | ex_branch_taken;
      if (FWD_EN) begin
        fwd_a_sel = pick(a_fwd_mem, a_fwd_wb);
        fwd_b_sel = pick(b_fwd_mem, b_fwd_wb);
      end
    end
  end

  // Next EX entry: ID fields, invalidated when a bubble is inserted
  always_comb begin
    id_c          = '0;
    id_c.valid    = id_valid & ~ex_bubble;
    id_c.dst      = id_dst;
    id_c.dst_en   = id_dst_en;
    id_c.is_load  = id_is_load;
    id_c.src_a    = id_src_a;
    id_c.src_b    = id_src_b;
    id_c.src_a_en = id_src_a_en;
    id_c.src_b_en = id_src_b_en;
  end

  // Shadow pipeline advance and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= id_c;
      if (hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Older-stage fields carried in full for debug visibility only
  logic unused_shadow;
  assign unused_shadow = ^{mem_q.is_load, mem_q.src_a, mem_q.src_b,
                           mem_q.src_a_en, mem_q.src_b_en,
                           wb_q.is_load, wb_q.src_a, wb_q.src_b,
                           wb_q.src_a_en, wb_q.src_b_en};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: bench for hazard_ctrl. Three instances share one input
// stream: no forwarding, forwarding, and no forwarding with a 2-bit counter.
// A per-instance instruction-history model predicts every output.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_src_a, id_src_b, id_dst;
  logic       id_src_a_en, id_src_b_en, id_dst_en, id_is_load;
  logic       ex_branch_taken;

  logic       hz [3];
  logic       bb [3];
  logic       fl [3];
  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_en(id_src_a_en), .id_src_b_en(id_src_b_en),
    .id_dst(id_dst), .id_dst_en(id_dst_en), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .hazard(hz[0]), .ex_bubble(bb[0]), .flush(fl[0]),
    .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .stall_cnt(sc0));

  hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_en(id_src_a_en), .id_src_b_en(id_src_b_en),
    .id_dst(id_dst), .id_dst_en(id_dst_en), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .hazard(hz[1]), .ex_bubble(bb[1]), .flush(fl[1]),
    .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .stall_cnt(sc1));

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_en(id_src_a_en), .id_src_b_en(id_src_b_en),
    .id_dst(id_dst), .id_dst_en(id_dst_en), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .hazard(hz[2]), .ex_bubble(bb[2]), .flush(fl[2]),
    .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]), .stall_cnt(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Model: the three instructions issued most recently, age 0 = youngest
  typedef struct {
    bit v; int dst; bit den; bit ld; int sa; int sb; bit sae; bit sbe;
  } ins_t;

  ins_t        hist [3][3];
  longint      cnt  [3];
  bit          fwd_of [3] = '{1'b0, 1'b1, 1'b0};
  longint      cmax   [3] = '{65535, 65535, 3};
  bit          e_hz [3], e_bb [3], e_fl [3];
  int          e_fa [3], e_fb [3];

  function automatic bit produces(ins_t e, int r, bit used);
    return used && e.v && e.den && (r != 0) && (e.dst == r);
  endfunction

  function automatic int src_sel(int i, int r, bit used);
    if (produces(hist[i][1], r, used)) return 1;
    if (produces(hist[i][2], r, used)) return 2;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict(int i);
    int  a, b;
    bit  blocked;
    a = int'(id_src_a);
    b = int'(id_src_b);
    e_hz[i] = 0; e_bb[i] = 0; e_fl[i] = 0; e_fa[i] = 0; e_fb[i] = 0;
    if (!reset) begin
      if (fwd_of[i])
        blocked = hist[i][0].ld && (produces(hist[i][0], a, id_src_a_en) ||
                                    produces(hist[i][0], b, id_src_b_en));
      else
        blocked = produces(hist[i][0], a, id_src_a_en) || produces(hist[i][0], b, id_src_b_en) ||
                  produces(hist[i][1], a, id_src_a_en) || produces(hist[i][1], b, id_src_b_en);
      blocked  = blocked && id_valid;
      e_fl[i]  = ex_branch_taken;
      e_hz[i]  = blocked && !ex_branch_taken;
      e_bb[i]  = e_hz[i] || ex_branch_taken;
      if (fwd_of[i] && hist[i][0].v) begin
        e_fa[i] = src_sel(i, hist[i][0].sa, hist[i][0].sae);
        e_fb[i] = src_sel(i, hist[i][0].sb, hist[i][0].sbe);
      end
    end
  endtask

  // Compare combinational outputs mid-cycle
  task automatic check_comb();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      predict(i);
      chk($sformatf("hazard%0d", i),    32'(hz[i]), 32'(e_hz[i]));
      chk($sformatf("ex_bubble%0d", i), 32'(bb[i]), 32'(e_bb[i]));
      chk($sformatf("flush%0d", i),     32'(fl[i]), 32'(e_fl[i]));
      chk($sformatf("fwd_a%0d", i),     32'(fa[i]), 32'(e_fa[i]));
      chk($sformatf("fwd_b%0d", i),     32'(fb[i]), 32'(e_fb[i]));
    end
  endtask

  // Advance the model across the clock edge and compare counters
  task automatic edge_step();
    ins_t n;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        for (int k = 0; k < 3; k++) hist[i][k] = '{default: 0};
        cnt[i] = 0;
      end else begin
        if (e_hz[i] && cnt[i] < cmax[i]) cnt[i]++;
        n.v   = id_valid && !e_bb[i];
        n.dst = int'(id_dst);   n.den = id_dst_en; n.ld = id_is_load;
        n.sa  = int'(id_src_a); n.sae = id_src_a_en;
        n.sb  = int'(id_src_b); n.sbe = id_src_b_en;
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = n;
      end
    end
    chk("stall_cnt0", 32'(sc0), 32'(cnt[0]));
    chk("stall_cnt1", 32'(sc1), 32'(cnt[1]));
    chk("stall_cnt2", 32'(sc2), 32'(cnt[2]));
  endtask

  task automatic cycle();
    check_comb();
    edge_step();
  endtask

  task automatic set_id(bit v, int sa, bit sae, int sb, bit sbe, int dst, bit den, bit ld, bit br);
    id_valid = v;
    id_src_a = 5'(sa); id_src_a_en = sae;
    id_src_b = 5'(sb); id_src_b_en = sbe;
    id_dst   = 5'(dst); id_dst_en = den;
    id_is_load = ld;
    ex_branch_taken = br;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset with an aggressive ID pattern and a taken branch: all outputs quiet
    reset = 1'b1;
    set_id(1, 1, 1, 2, 1, 3, 1, 1, 1);
    cycle();
    cycle();
    reset = 1'b0;

    // add r3 then a reader of r3: two stalls without forwarding
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cycle();
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
    check_comb();
    chk("r3_hz_c1", 32'(hz[0]), 32'd1);
    chk("r3_bb_c1", 32'(bb[0]), 32'd1);
    chk("r3_fwd_hz_c1", 32'(hz[1]), 32'd0);
    edge_step();
    check_comb();
    chk("r3_hz_c2", 32'(hz[0]), 32'd1);
    chk("r3_bb_c2", 32'(bb[0]), 32'd1);
    edge_step();
    check_comb();
    chk("r3_hz_c3", 32'(hz[0]), 32'd0);
    edge_step();
    chk("r3_cnt", 32'(sc0), 32'd2);
    idle();
    cycle();
    cycle();

    // load r5 then a reader of r5: one stall with forwarding, then WB forward
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cycle();
    set_id(1, 0, 0, 5, 1, 0, 0, 0, 0);
    check_comb();
    chk("r5_hz_c1", 32'(hz[1]), 32'd1);
    edge_step();
    check_comb();
    chk("r5_hz_c2", 32'(hz[1]), 32'd0);
    edge_step();
    idle();
    check_comb();
    chk("r5_fwd_b", 32'(fb[1]), 32'd2);
    chk("r5_nofwd_b", 32'(fb[0]), 32'd0);
    edge_step();
    chk("r5_cnt", 32'(sc1), 32'd1);

    // add r4, add r4, reader of r4: MEM wins over WB
    do_reset();
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0);
    cycle();
    cycle();
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
    check_comb();
    chk("r4_hz", 32'(hz[1]), 32'd0);
    edge_step();
    idle();
    check_comb();
    chk("r4_fwd_a", 32'(fa[1]), 32'd1);
    edge_step();

    // register 0 never creates a dependency
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle();
    set_id(1, 0, 1, 0, 1, 0, 1, 0, 0);
    check_comb();
    chk("r0_hz_nofwd", 32'(hz[0]), 32'd0);
    chk("r0_hz_fwd", 32'(hz[1]), 32'd0);
    edge_step();
    idle();
    cycle();

    // taken branch during a load-use stall: flush wins
    do_reset();
    set_id(1, 0, 0, 0, 0, 6, 1, 1, 0);
    cycle();
    set_id(1, 6, 1, 0, 0, 0, 0, 0, 1);
    check_comb();
    chk("br_flush", 32'(fl[0]), 32'd1);
    chk("br_hz", 32'(hz[0]), 32'd0);
    chk("br_bb", 32'(bb[0]), 32'd1);
    chk("br_hz_fwd", 32'(hz[1]), 32'd0);
    edge_step();
    chk("br_cnt", 32'(sc0), 32'd0);
    idle();
    cycle();

    // reset in the middle of a stall drops it
    do_reset();
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0);
    cycle();
    set_id(1, 2, 1, 0, 0, 0, 0, 0, 0);
    check_comb();
    chk("ms_hz_pre", 32'(hz[0]), 32'd1);
    edge_step();
    reset = 1'b1;
    check_comb();
    chk("ms_hz_rst", 32'(hz[0]), 32'd0);
    edge_step();
    reset = 1'b0;
    check_comb();
    chk("ms_hz_post", 32'(hz[0]), 32'd0);
    edge_step();

    // six stall cycles saturate a 2-bit counter at 3
    do_reset();
    for (int r = 0; r < 3; r++) begin
      set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
      cycle();
      set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cycle();
    end
    chk("sat_cnt2", 32'(sc2), 32'd3);
    chk("sat_cnt0", 32'(sc0), 32'd6);
    reset = 1'b1;
    set_id(1, 7, 1, 7, 1, 7, 1, 1, 1);
    check_comb();
    chk("sat_rst_flush", 32'(fl[2]), 32'd0);
    chk("sat_rst_bb", 32'(bb[2]), 32'd0);
    edge_step();
    chk("sat_rst_cnt", 32'(sc2), 32'd0);
    reset = 1'b0;

    // randomized traffic over a small register set; ID often held
    idle();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 1) == 0 || n == 0) begin
        set_id($urandom_range(0, 4) != 0,
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
      end
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FWD_EN, default 0: 1 = forwarding enabled, stall only on load-use.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_cnt.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_src_a, id_src_b  input  5 each  ID source register numbers.
REQ-007 SHALL have ports id_src_a_en, id_src_b_en  input  1 each  source actually read.
REQ-008 SHALL have port id_dst  input  5  ID destination register.
REQ-009 SHALL have port id_dst_en  input  1  ID instruction writes id_dst.
REQ-010 SHALL have port id_is_load  input  1  ID instruction is a load.
REQ-011 SHALL have port ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-012 SHALL have port hazard  output  1  to fetch: hold PC and IF/ID register.
REQ-013 SHALL have port ex_bubble  output  1  force NOP into ID/EX register.
REQ-014 SHALL have port flush  output  1  squash IF/ID contents.
REQ-015 SHALL have ports fwd_a_sel, fwd_b_sel  output  2 each  EX operand source: 00 regfile, 01 MEM result, 10 WB result.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of stalled cycles.

Function
REQ-017 SHALL keep shadow entries EX, MEM, WB, each {valid, dst, dst_en, is_load, src_a, src_b, src_a_en, src_b_en}.
REQ-018 Each edge, unless reset: WB<=MEM, MEM<=EX, EX<=ID fields; EX.valid<=id_valid & ~ex_bubble.
REQ-019 Source match: src_en=1, src!=0, and an entry with valid=1, dst_en=1, dst==src; register 0 never matches.
REQ-020 FWD_EN=0: raw_stall = id_valid & source match against EX or MEM; WB excluded (regfile write-through).
REQ-021 FWD_EN=1: raw_stall = id_valid & source match against EX with EX.is_load=1 only.
REQ-022 hazard = raw_stall & ~ex_branch_taken, combinational, same cycle as ID inputs.
REQ-023 flush = ex_branch_taken, combinational; ex_bubble = hazard | ex_branch_taken.
REQ-024 Branch-and-stall in same cycle: flush wins; hazard=0; ID instruction discarded, not held.
REQ-025 FWD_EN=1: fwd_x_sel from EX entry sources: 01 if MEM match, else 10 if WB match, else 00; MEM has priority over WB.
REQ-026 FWD_EN=0: fwd_a_sel=fwd_b_sel=00 always.
REQ-027 Stall length: FWD_EN=0 max 2 consecutive cycles per dependency; FWD_EN=1 exactly 1 cycle per load-use.
REQ-028 stall_cnt increments by 1 each cycle hazard=1; saturates at all-ones, no wrap.
REQ-029 Stalled ID instruction re-evaluated each cycle with same inputs; upstream holds them stable while hazard=1.

Reset
REQ-030 reset=1 at an edge SHALL clear all shadow valid bits and stall_cnt to 0; dst/src fields to 0.
REQ-031 While reset=1: hazard, flush, ex_bubble = 0; fwd_a_sel, fwd_b_sel = 00.
REQ-032 Reset mid-stall SHALL drop the stall; first cycle after release sees an empty pipeline.

Verification
REQ-033 FWD_EN=0: add r3 (dst_en, dst=3), then ID src_a=3 -> hazard=1 two cycles, ex_bubble=1 two cycles, stall_cnt=2, third cycle hazard=0.
REQ-034 FWD_EN=1: load r5, next ID src_b=5 -> hazard=1 one cycle; next cycle fwd_b_sel=10... precisely: instruction in EX sees load in WB -> fwd_b_sel=10.
REQ-035 FWD_EN=1: add r4 then add r4 then ID uses r4 -> no stall, EX fwd_a_sel=01 (MEM wins over WB).
REQ-036 Dependency on r0 (dst=0, src_a=0) -> hazard=0 always.
REQ-037 ex_branch_taken=1 while raw_stall true -> flush=1, hazard=0, ex_bubble=1, stall_cnt unchanged.
REQ-038 CNT_W=2, force 5 stall cycles -> stall_cnt holds 3; reset=1 one cycle -> stall_cnt=0, all outputs 0.
